victim_cache_ctrl: RTL

- Sequences the victim cache that sits beside the write-back dcache.
- Holds tag, valid and dirty metadata for a small fully associative victim buffer, and answers dcache lookups with hit and entry index.
- Accepts lines evicted from the dcache and chooses the replacement entry.
- Writes dirty displaced entries back to data memory, and flushes the buffer on request. The line data array is external and is driven by this block's index and write-strobe outputs.

---
 rtl/vc_pkg.sv | 23 ++
 rtl/vc_repl_policy.sv | 86 ++++++++
 rtl/victim_cache_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the victim cache controller.
//   - Default geometry for the victim buffer (entry count, line address width).
//   - vc_idx_bits(): entry index width derived from the entry count.
//   - type_vc_states_e: controller sequencing states.
package vc_pkg;

  localparam int VC_ENTRIES_DEF  = 4;
  localparam int VC_TAG_BITS_DEF = 28;

  function automatic int vc_idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  typedef enum logic [2:0] {
    VC_IDLE       = 3'd0,
    VC_LOOKUP     = 3'd1,
    VC_INSERT     = 3'd2,
    VC_WRITE_BACK = 3'd3,
    VC_FLUSH      = 3'd4,
    VC_FLUSH_DONE = 3'd5
  } type_vc_states_e;

endpackage

// File: rtl/vc_repl_policy.sv
// Victim selection for the victim buffer.
// The lowest invalid entry is always preferred. When every entry is valid the
// choice falls to the replacement state:
//   default build      : round-robin pointer, advanced on each replacement of
//                        a valid entry.
//   VC_LRU_EN defined   : true LRU, one age counter per entry; the oldest
//                        (age VC_ENTRIES-1) is chosen.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_valid         current valid vector (swap already applied)
//   i_access        an entry was hit or written; i_access_idx names it
//   i_replace       a valid entry was just replaced
//   o_victim_idx    entry to use for the next insert
module vc_repl_policy
  import vc_pkg::*;
#(
  parameter int VC_ENTRIES  = VC_ENTRIES_DEF,
  parameter int VC_IDX_BITS = vc_idx_bits(VC_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VC_ENTRIES-1:0]  i_valid,
  input  logic                   i_access,
  input  logic [VC_IDX_BITS-1:0] i_access_idx,
  input  logic                   i_replace,
  output logic [VC_IDX_BITS-1:0] o_victim_idx
);

  logic                   w_has_free;
  logic [VC_IDX_BITS-1:0] w_free_idx;
  logic [VC_IDX_BITS-1:0] w_pol_idx;

  // Scan downwards so the lowest invalid index is the one left standing.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = VC_IDX_BITS'(i);
      end
    end
  end

`ifdef VC_LRU_EN
  logic [VC_IDX_BITS-1:0] r_age [VC_ENTRIES];
  logic                   w_unused_replace;

  assign w_unused_replace = i_replace;

  // Ages start as a permutation 0..N-1 and every update keeps them one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC_ENTRIES; i++) r_age[i] <= VC_IDX_BITS'(i);
    end else if (i_access) begin
      for (int i = 0; i < VC_ENTRIES; i++) begin
        if (VC_IDX_BITS'(i) == i_access_idx) r_age[i] <= '0;
        else if (r_age[i] < r_age[i_access_idx]) r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_pol_idx = '0;
    for (int i = 0; i < VC_ENTRIES; i++) begin
      if (r_age[i] == VC_IDX_BITS'(VC_ENTRIES - 1)) w_pol_idx = VC_IDX_BITS'(i);
    end
  end
`else
  logic [VC_IDX_BITS-1:0] r_ptr;
  logic                   w_unused_access;

  assign w_unused_access = i_access ^ (^i_access_idx);

  // Entry count is a power of two, so natural wrap gives the modulo.
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (i_replace) r_ptr <= r_ptr + 1'b1;
  end

  assign w_pol_idx = r_ptr;
`endif

  assign o_victim_idx = w_has_free ? w_free_idx : w_pol_idx;

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: owns tag/valid/dirty metadata for a small fully
// associative victim buffer beside the write-back dcache. The line data array
// is external and addressed by vc_data_idx_o / vc_data_wr_o.
// Optional feature: define VC_LRU_EN for true-LRU replacement (default is
// round-robin); see vc_repl_policy.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   lookup_req_i/lookup_addr_i        dcache lookup (pulse)
//   lookup_ack_o/vc_hit_o/vc_hit_idx_o lookup result, one cycle later
//   swap_i                            invalidate entry vc_hit_idx_o
//   insert_req_i/addr/dirty           evicted line, held until insert_ack_o
//   vc_data_wr_o/vc_data_idx_o        data array strobe and index
//   vc2mem_req_o/wr_o/addr_o          writeback request, mem2vc_ack_i accepts
//   flush_i/flush_done_o              write back dirty + invalidate all
//   kill_i                            abort the current operation
module victim_cache_ctrl
  import vc_pkg::*;
#(
  parameter int VC_ENTRIES  = VC_ENTRIES_DEF,
  parameter int VC_TAG_BITS = VC_TAG_BITS_DEF,
  parameter int VC_IDX_BITS = vc_idx_bits(VC_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req_i,
  input  logic [VC_TAG_BITS-1:0] lookup_addr_i,
  output logic                   vc_hit_o,
  output logic [VC_IDX_BITS-1:0] vc_hit_idx_o,
  output logic                   lookup_ack_o,
  input  logic                   swap_i,
  input  logic                   insert_req_i,
  input  logic [VC_TAG_BITS-1:0] insert_addr_i,
  input  logic                   insert_dirty_i,
  output logic                   insert_ack_o,
  output logic                   vc_data_wr_o,
  output logic [VC_IDX_BITS-1:0] vc_data_idx_o,
  output logic                   vc2mem_req_o,
  output logic                   vc2mem_wr_o,
  output logic [VC_TAG_BITS-1:0] vc2mem_addr_o,
  input  logic                   mem2vc_ack_i,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  input  logic                   kill_i
);

  localparam logic [VC_IDX_BITS-1:0] LAST_IDX = VC_IDX_BITS'(VC_ENTRIES - 1);

  type_vc_states_e        r_state, w_next;
  logic [VC_ENTRIES-1:0]  r_valid, r_dirty;
  logic [VC_TAG_BITS-1:0] r_tag [VC_ENTRIES];
  logic [VC_TAG_BITS-1:0] r_addr;
  logic                   r_in_dirty, r_dup, r_was_valid, r_flush;
  logic [VC_IDX_BITS-1:0] r_victim, r_hit_idx;

  logic [VC_ENTRIES-1:0]  w_valid_eff;
  logic                   w_lk_hit, w_dup;
  logic [VC_IDX_BITS-1:0] w_lk_idx, w_dup_idx, w_pol_idx, w_sel_idx, w_acc_idx;
  logic                   w_idle_go, w_commit_ins, w_wb_done, w_flush_clean;
  logic                   w_acc, w_repl;

  // Lookup compare against the registered address; lowest index wins.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == r_addr)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = VC_IDX_BITS'(i);
      end
    end
  end

  // The hit index is held after the lookup so a later swap_i still names it.
  assign vc_hit_idx_o = (r_state == VC_LOOKUP) ? w_lk_idx : r_hit_idx;

  // A same-cycle swap frees its slot before insert selection sees it.
  always_comb begin
    w_valid_eff = r_valid;
    if (swap_i) w_valid_eff[vc_hit_idx_o] = 1'b0;
    w_dup     = 1'b0;
    w_dup_idx = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (w_valid_eff[i] && (r_tag[i] == insert_addr_i)) begin
        w_dup     = 1'b1;
        w_dup_idx = VC_IDX_BITS'(i);
      end
    end
  end

  assign w_sel_idx = w_dup ? w_dup_idx : w_pol_idx;

  assign w_idle_go     = (r_state == VC_IDLE) && !kill_i;
  assign w_commit_ins  = (r_state == VC_INSERT) && !kill_i;
  assign w_wb_done     = (r_state == VC_WRITE_BACK) && mem2vc_ack_i && !kill_i;
  assign w_flush_clean = (r_state == VC_FLUSH) && !kill_i &&
                         !(r_valid[r_victim] && r_dirty[r_victim]);

  assign w_acc     = ((r_state == VC_LOOKUP) && !kill_i && w_lk_hit) || w_commit_ins;
  assign w_acc_idx = (r_state == VC_INSERT) ? r_victim : w_lk_idx;
  // Only displacing a live, different line counts as a replacement.
  assign w_repl    = w_commit_ins && !r_dup && r_was_valid;

  vc_repl_policy #(
    .VC_ENTRIES  (VC_ENTRIES),
    .VC_IDX_BITS (VC_IDX_BITS)
  ) u_repl (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (w_valid_eff),
    .i_access     (w_acc),
    .i_access_idx (w_acc_idx),
    .i_replace    (w_repl),
    .o_victim_idx (w_pol_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= VC_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    lookup_ack_o  = 1'b0;
    vc_hit_o      = 1'b0;
    insert_ack_o  = 1'b0;
    vc_data_wr_o  = 1'b0;
    vc_data_idx_o = '0;
    vc2mem_req_o  = 1'b0;
    vc2mem_addr_o = '0;
    flush_done_o  = 1'b0;
    unique case (r_state)
      VC_IDLE: begin
        if (flush_i) begin
          w_next = VC_FLUSH;
        end else if (insert_req_i) begin
          // Dirty live victim (not an in-place update) must be written back first.
          if (!w_dup && w_valid_eff[w_sel_idx] && r_dirty[w_sel_idx]) w_next = VC_WRITE_BACK;
          else w_next = VC_INSERT;
        end else if (lookup_req_i) begin
          w_next = VC_LOOKUP;
        end
      end
      VC_LOOKUP: begin
        lookup_ack_o  = 1'b1;
        vc_hit_o      = w_lk_hit;
        vc_data_idx_o = w_lk_idx;
        w_next        = VC_IDLE;
      end
      VC_INSERT: begin
        insert_ack_o  = 1'b1;
        vc_data_wr_o  = 1'b1;
        vc_data_idx_o = r_victim;
        w_next        = VC_IDLE;
      end
      VC_WRITE_BACK: begin
        vc2mem_req_o  = 1'b1;
        vc2mem_addr_o = r_tag[r_victim];
        vc_data_idx_o = r_victim;
        if (mem2vc_ack_i) w_next = r_flush ? VC_FLUSH : VC_INSERT;
      end
      VC_FLUSH: begin
        vc_data_idx_o = r_victim;
        if (r_valid[r_victim] && r_dirty[r_victim]) w_next = VC_WRITE_BACK;
        else if (r_victim == LAST_IDX) w_next = VC_FLUSH_DONE;
      end
      VC_FLUSH_DONE: begin
        flush_done_o = 1'b1;
        w_next       = VC_IDLE;
      end
      default: w_next = VC_IDLE;
    endcase
    // Kill takes effect combinationally: request and strobes drop this cycle.
    if (kill_i) begin
      w_next        = VC_IDLE;
      lookup_ack_o  = 1'b0;
      vc_hit_o      = 1'b0;
      insert_ack_o  = 1'b0;
      vc_data_wr_o  = 1'b0;
      vc2mem_req_o  = 1'b0;
      vc2mem_addr_o = '0;
      flush_done_o  = 1'b0;
    end
  end

  assign vc2mem_wr_o = vc2mem_req_o;

  // Metadata. Later assignments win, so an insert commit overrides a swap
  // that targets the same entry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      r_dirty   <= '0;
      r_flush   <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      if (swap_i) r_valid[vc_hit_idx_o] <= 1'b0;
      if (w_idle_go) begin
        if (flush_i) r_flush <= 1'b1;
        else if (insert_req_i) r_flush <= 1'b0;
      end
      if ((r_state == VC_LOOKUP) && !kill_i && w_lk_hit) r_hit_idx <= w_lk_idx;
      if (w_commit_ins) begin
        r_valid[r_victim] <= 1'b1;
        r_dirty[r_victim] <= r_in_dirty | (r_dup & r_dirty[r_victim]);
      end
      if (w_wb_done) begin
        r_dirty[r_victim] <= 1'b0;
        if (r_flush) r_valid[r_victim] <= 1'b0;
      end
      if (w_flush_clean) begin
        r_valid[r_victim] <= 1'b0;
        r_dirty[r_victim] <= 1'b0;
      end
    end
  end

  // Operation context and tag storage; only meaningful once a state uses them.
  always_ff @(posedge clk) begin
    if (w_idle_go) begin
      if (flush_i) begin
        r_victim <= '0;
      end else if (insert_req_i) begin
        r_addr      <= insert_addr_i;
        r_in_dirty  <= insert_dirty_i;
        r_dup       <= w_dup;
        r_victim    <= w_sel_idx;
        r_was_valid <= w_valid_eff[w_sel_idx];
      end else if (lookup_req_i) begin
        r_addr <= lookup_addr_i;
      end
    end
    if (w_flush_clean && (r_victim != LAST_IDX)) r_victim <= r_victim + 1'b1;
    if (w_commit_ins) r_tag[r_victim] <= r_addr;
  end

endmodule
